// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC, IF/ID register, stall,
// branch redirect, interrupt entry and one/two-word instruction support.
// Ports:
//   clk, reset (sync, active-low)
//   imem_addr / imem_rdata : combinational-read instruction memory
//   stall, redirect, redirect_pc : pipeline control from later stages
//   intr / intr_ack / intr_ret_pc : interrupt request, ack pulse, return PC
//   ifid_* : IF/ID register feeding decode
module fetch_stage #(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned RESET_PC = 32,
   parameter int unsigned INT_VEC  = 0,
   parameter int unsigned IMM_BIT  = 0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               intr,
   output logic               intr_ack,
   output logic [ADDR_W-1:0]  intr_ret_pc,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_op,
   output logic [INSTR_W-1:0] ifid_imm,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic               ifid_two_word
);

   typedef enum logic {
      ST_OP  = 1'b0,
      ST_IMM = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] op_hold_q, op_hold_d;
   logic [ADDR_W-1:0]  op_pc_q, op_pc_d;
   logic               intr_ack_q, intr_ack_d;
   logic [ADDR_W-1:0]  intr_ret_pc_q, intr_ret_pc_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [INSTR_W-1:0] ifid_op_q, ifid_op_d;
   logic [INSTR_W-1:0] ifid_imm_q, ifid_imm_d;
   logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
   logic               ifid_two_word_q, ifid_two_word_d;

   logic [ADDR_W-1:0]  pc_inc;

   assign pc_inc = pc_q + ADDR_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ST_OP;
         pc_q            <= ADDR_W'(RESET_PC);
         op_hold_q       <= '0;
         op_pc_q         <= '0;
         intr_ack_q      <= 1'b0;
         intr_ret_pc_q   <= '0;
         ifid_valid_q    <= 1'b0;
         ifid_op_q       <= '0;
         ifid_imm_q      <= '0;
         ifid_pc_q       <= '0;
         ifid_two_word_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         op_hold_q       <= op_hold_d;
         op_pc_q         <= op_pc_d;
         intr_ack_q      <= intr_ack_d;
         intr_ret_pc_q   <= intr_ret_pc_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_op_q       <= ifid_op_d;
         ifid_imm_q      <= ifid_imm_d;
         ifid_pc_q       <= ifid_pc_d;
         ifid_two_word_q <= ifid_two_word_d;
      end
   end

   // Next state: intr > redirect > stall > normal fetch
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      op_hold_d       = op_hold_q;
      op_pc_d         = op_pc_q;
      intr_ack_d      = 1'b0;
      intr_ret_pc_d   = intr_ret_pc_q;
      ifid_valid_d    = ifid_valid_q;
      ifid_op_d       = ifid_op_q;
      ifid_imm_d      = ifid_imm_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_two_word_d = ifid_two_word_q;

      if (intr) begin
         // A half-fetched two-word instruction restarts from its opcode word
         if (state_q == ST_IMM) begin
            intr_ret_pc_d = op_pc_q;
         end else if (redirect) begin
            intr_ret_pc_d = redirect_pc;
         end else begin
            intr_ret_pc_d = pc_q;
         end
         pc_d         = ADDR_W'(INT_VEC);
         state_d      = ST_OP;
         ifid_valid_d = 1'b0;
         intr_ack_d   = 1'b1;
      end else if (redirect) begin
         pc_d         = redirect_pc;
         state_d      = ST_OP;
         ifid_valid_d = 1'b0;
      end else if (!stall) begin
         pc_d = pc_inc;
         if (state_q == ST_OP) begin
            if (imem_rdata[IMM_BIT]) begin
               // Opcode of a two-word instruction: park it, emit a bubble
               op_hold_d    = imem_rdata;
               op_pc_d      = pc_q;
               state_d      = ST_IMM;
               ifid_valid_d = 1'b0;
            end else begin
               ifid_op_d       = imem_rdata;
               ifid_imm_d      = '0;
               ifid_pc_d       = pc_q;
               ifid_two_word_d = 1'b0;
               ifid_valid_d    = 1'b1;
            end
         end else begin
            ifid_op_d       = op_hold_q;
            ifid_imm_d      = imem_rdata;
            ifid_pc_d       = op_pc_q;
            ifid_two_word_d = 1'b1;
            ifid_valid_d    = 1'b1;
            state_d         = ST_OP;
         end
      end
   end

   assign imem_addr     = pc_q;
   assign intr_ack      = intr_ack_q;
   assign intr_ret_pc   = intr_ret_pc_q;
   assign ifid_valid    = ifid_valid_q;
   assign ifid_op       = ifid_op_q;
   assign ifid_imm      = ifid_imm_q;
   assign ifid_pc       = ifid_pc_q;
   assign ifid_two_word = ifid_two_word_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with default parameters.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [19:0] redirect_pc;
   logic        intr;
   logic        intr_ack;
   logic [19:0] intr_ret_pc;
   logic        ifid_valid;
   logic [15:0] ifid_op;
   logic [15:0] ifid_imm;
   logic [19:0] ifid_pc;
   logic        ifid_two_word;

   int errors = 0;
   int checks = 0;

   // Small memory aliased on the low 9 address bits
   logic [15:0] mem [0:511];
   assign imem_rdata = mem[imem_addr[8:0]];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .intr(intr), .intr_ack(intr_ack), .intr_ret_pc(intr_ret_pc),
      .ifid_valid(ifid_valid), .ifid_op(ifid_op), .ifid_imm(ifid_imm),
      .ifid_pc(ifid_pc), .ifid_two_word(ifid_two_word)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; intr = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      mem[32] = 16'h1000; mem[33] = 16'h2002; mem[34] = 16'h3004;
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", ifid_valid); end
      checks++; if (ifid_op !== 16'h0) begin errors++; $display("FAIL rst_op got=%0h exp=0", ifid_op); end
      checks++; if (intr_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%0h exp=0", intr_ack); end
      checks++; if (intr_ret_pc !== 20'h0) begin errors++; $display("FAIL rst_retpc got=%0h exp=0", intr_ret_pc); end
      reset = 1'b1;
      #1;
      checks++; if (imem_addr !== 20'd32) begin errors++; $display("FAIL rst_addr got=%0h exp=20", imem_addr); end
      tick();
      checks++; if (ifid_op !== 16'h1000 || ifid_pc !== 20'd32 || ifid_valid !== 1'b1 || ifid_two_word !== 1'b0 || ifid_imm !== 16'h0)
         begin errors++; $display("FAIL seq0 got op=%0h pc=%0h v=%0b tw=%0b imm=%0h exp op=1000 pc=20 v=1 tw=0 imm=0", ifid_op, ifid_pc, ifid_valid, ifid_two_word, ifid_imm); end
      tick();
      checks++; if (ifid_op !== 16'h2002 || ifid_pc !== 20'd33 || ifid_valid !== 1'b1)
         begin errors++; $display("FAIL seq1 got op=%0h pc=%0h v=%0b exp op=2002 pc=21 v=1", ifid_op, ifid_pc, ifid_valid); end
      tick();
      checks++; if (ifid_op !== 16'h3004 || ifid_pc !== 20'd34 || ifid_valid !== 1'b1)
         begin errors++; $display("FAIL seq2 got op=%0h pc=%0h v=%0b exp op=3004 pc=22 v=1", ifid_op, ifid_pc, ifid_valid); end
   endtask

   task automatic test_two_word();
      do_reset();
      mem[32] = 16'h0A01; mem[33] = 16'hBEEF;
      reset = 1'b1;
      tick();
      checks++; if (ifid_valid !== 1'b0 || imem_addr !== 20'd33)
         begin errors++; $display("FAIL tw_bubble got v=%0b addr=%0h exp v=0 addr=21", ifid_valid, imem_addr); end
      tick();
      checks++; if (ifid_op !== 16'h0A01 || ifid_imm !== 16'hBEEF || ifid_pc !== 20'd32 || ifid_two_word !== 1'b1 || ifid_valid !== 1'b1)
         begin errors++; $display("FAIL tw_issue got op=%0h imm=%0h pc=%0h tw=%0b v=%0b exp op=a01 imm=beef pc=20 tw=1 v=1", ifid_op, ifid_imm, ifid_pc, ifid_two_word, ifid_valid); end
      checks++; if (imem_addr !== 20'd34) begin errors++; $display("FAIL tw_addr got=%0h exp=22", imem_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      mem[32] = 16'h1000; mem[33] = 16'h2002; mem[34] = 16'h3004;
      reset = 1'b1;
      tick();
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ifid_op !== 16'h2002 || ifid_pc !== 20'd33 || ifid_valid !== 1'b1 || ifid_imm !== 16'h0 || ifid_two_word !== 1'b0 || imem_addr !== 20'd34)
            begin errors++; $display("FAIL stall_hold%0d got op=%0h pc=%0h v=%0b addr=%0h exp op=2002 pc=21 v=1 addr=22", i, ifid_op, ifid_pc, ifid_valid, imem_addr); end
      end
      stall = 1'b0;
      tick();
      checks++; if (ifid_op !== 16'h3004 || ifid_pc !== 20'd34 || imem_addr !== 20'd35)
         begin errors++; $display("FAIL stall_resume got op=%0h pc=%0h addr=%0h exp op=3004 pc=22 addr=23", ifid_op, ifid_pc, imem_addr); end
   endtask

   task automatic test_redirect();
      do_reset();
      mem[32] = 16'h0A01; mem[33] = 16'hBEEF; mem[256] = 16'h5550;
      reset = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 20'h100;
      tick();
      checks++; if (ifid_valid !== 1'b0 || imem_addr !== 20'h100)
         begin errors++; $display("FAIL redir got v=%0b addr=%0h exp v=0 addr=100", ifid_valid, imem_addr); end
      redirect = 1'b0;
      tick();
      checks++; if (ifid_op !== 16'h5550 || ifid_pc !== 20'h100 || ifid_valid !== 1'b1 || ifid_two_word !== 1'b0)
         begin errors++; $display("FAIL redir_issue got op=%0h pc=%0h v=%0b tw=%0b exp op=5550 pc=100 v=1 tw=0", ifid_op, ifid_pc, ifid_valid, ifid_two_word); end
   endtask

   task automatic test_intr();
      do_reset();
      mem[40] = 16'h0C03; mem[41] = 16'h1234; mem[0] = 16'h7000;
      reset = 1'b1;
      redirect = 1'b1; redirect_pc = 20'd40;
      tick();
      redirect = 1'b0;
      tick();
      checks++; if (imem_addr !== 20'd41 || ifid_valid !== 1'b0)
         begin errors++; $display("FAIL intr_setup got addr=%0h v=%0b exp addr=29 v=0", imem_addr, ifid_valid); end
      intr = 1'b1;
      tick();
      checks++; if (intr_ret_pc !== 20'd40 || imem_addr !== 20'h0 || intr_ack !== 1'b1 || ifid_valid !== 1'b0)
         begin errors++; $display("FAIL intr_entry got ret=%0h addr=%0h ack=%0b v=%0b exp ret=28 addr=0 ack=1 v=0", intr_ret_pc, imem_addr, intr_ack, ifid_valid); end
      intr = 1'b0;
      tick();
      checks++; if (intr_ack !== 1'b0 || ifid_op !== 16'h7000 || ifid_pc !== 20'h0 || ifid_valid !== 1'b1 || intr_ret_pc !== 20'd40)
         begin errors++; $display("FAIL intr_after got ack=%0b op=%0h pc=%0h v=%0b ret=%0h exp ack=0 op=7000 pc=0 v=1 ret=28", intr_ack, ifid_op, ifid_pc, ifid_valid, intr_ret_pc); end
   endtask

   task automatic test_wrap_priority();
      do_reset();
      mem[511] = 16'h6000; mem[0] = 16'h7000;
      checks++; if (intr_ret_pc !== 20'h0) begin errors++; $display("FAIL wrap_rst_ret got=%0h exp=0", intr_ret_pc); end
      reset = 1'b1;
      redirect = 1'b1; redirect_pc = 20'hFFFFF;
      tick();
      redirect = 1'b0;
      tick();
      checks++; if (ifid_op !== 16'h6000 || ifid_pc !== 20'hFFFFF || imem_addr !== 20'h0)
         begin errors++; $display("FAIL wrap got op=%0h pc=%0h addr=%0h exp op=6000 pc=fffff addr=0", ifid_op, ifid_pc, imem_addr); end
      intr = 1'b1; redirect = 1'b1; redirect_pc = 20'h200; stall = 1'b1;
      tick();
      checks++; if (intr_ret_pc !== 20'h200 || imem_addr !== 20'h0 || intr_ack !== 1'b1 || ifid_valid !== 1'b0)
         begin errors++; $display("FAIL prio got ret=%0h addr=%0h ack=%0b v=%0b exp ret=200 addr=0 ack=1 v=0", intr_ret_pc, imem_addr, intr_ack, ifid_valid); end
      intr = 1'b0; redirect = 1'b0; stall = 1'b0;
      tick();
      checks++; if (intr_ack !== 1'b0 || ifid_op !== 16'h7000 || ifid_valid !== 1'b1)
         begin errors++; $display("FAIL prio_after got ack=%0b op=%0h v=%0b exp ack=0 op=7000 v=1", intr_ack, ifid_op, ifid_valid); end
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_stall();
      test_redirect();
      test_intr();
      test_wrap_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch stage with a program counter, an IF/ID output register, stall, branch redirect and interrupt entry.
- Supports one-word instructions and two-word instructions (opcode word followed by an immediate word).
- Drives a combinational-read instruction memory and feeds the decode stage of the pipelined processor.
- Replaces the fixed 5-cycle fetch pacing; a new instruction can issue every cycle.

Parameters:
- ADDR_W, 20, width of the PC and of the instruction-memory address (word addressed).
- INSTR_W, 16, instruction word width.
- RESET_PC, 32, PC value after reset; first word after the reserved interrupt area.
- INT_VEC, 0, PC loaded on interrupt entry.
- IMM_BIT, 0, bit of the opcode word that, when 1, marks a two-word instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- imem_addr  out  ADDR_W  instruction-memory address; combinational copy of the PC register.
- imem_rdata  in  INSTR_W  word at imem_addr, valid in the same cycle.
- stall  in  1  hold all fetch state this cycle.
- redirect  in  1  taken branch or jump.
- redirect_pc  in  ADDR_W  target PC for redirect.
- intr  in  1  interrupt request, single-cycle pulse.
- intr_ack  out  1  registered 1-cycle pulse, the cycle after intr is taken.
- intr_ret_pc  out  ADDR_W  registered return PC captured at interrupt entry.
- ifid_valid  out  1  IF/ID register holds a real instruction.
- ifid_op  out  INSTR_W  opcode word.
- ifid_imm  out  INSTR_W  immediate word; 0 for one-word instructions.
- ifid_pc  out  ADDR_W  address of the opcode word.
- ifid_two_word  out  1  instruction was two words.

Behaviour:
- Reset (reset=0 at an edge):
  - pc=RESET_PC, state=OP.
  - op_hold=0, op_pc=0.
  - All ifid_* outputs, intr_ack and intr_ret_pc = 0.
  - Reset taken mid-instruction (state IMM) drops the partial instruction.
- Per-edge priority: reset > intr > redirect > stall > normal fetch.
- Normal fetch, state OP, word w=imem_rdata:
  - If w[IMM_BIT]=0: ifid_op=w, ifid_imm=0, ifid_pc=pc, ifid_two_word=0, ifid_valid=1; pc=pc+1.
  - If w[IMM_BIT]=1: op_hold=w, op_pc=pc, pc=pc+1, state=IMM, ifid_valid=0 (bubble).
- Normal fetch, state IMM:
  - ifid_op=op_hold, ifid_imm=imem_rdata, ifid_pc=op_pc, ifid_two_word=1, ifid_valid=1.
  - pc=pc+1, state=OP.
- Throughput: a one-word instruction issues every cycle; a two-word instruction takes 2 cycles. Latency from pc to ifid_valid is 1 edge.
- PC arithmetic is modulo 2^ADDR_W: the all-ones address increments to 0 with no flag.
- Stall:
  - pc, state, op_hold, op_pc and all ifid_* outputs hold their values.
  - imem_addr stays constant.
- Redirect (no intr):
  - pc=redirect_pc, state=OP, ifid_valid=0; other ifid_* fields hold.
  - Overrides stall in the same cycle.
  - Abandons a pending immediate fetch.
- Interrupt entry (intr=1):
  - intr_ret_pc = op_pc if state=IMM, so the two-word instruction is refetched.
  - Otherwise intr_ret_pc = redirect_pc if redirect=1, else pc.
  - pc=INT_VEC, state=OP, ifid_valid=0.
  - intr_ack=1 for exactly the following cycle, otherwise 0.
  - intr is accepted even while stalled.
- ifid_valid depends only on the rules above; a stalled valid instruction stays valid.
- No combinational path from any input to any output except pc → imem_addr.

Test Plan:
- Reset to sequential fetch:
  - Stimulus: reset=0 for 2 cycles, then 1; memory[32..34] = 0x1000, 0x2002, 0x3004 (IMM_BIT=0, all one-word).
  - Required: imem_addr=32 at release; ifid_op = 0x1000, 0x2002, 0x3004 on 3 consecutive edges with ifid_pc = 32, 33, 34; ifid_valid=1 each cycle.
- Two-word instruction:
  - Stimulus: memory[32]=0x0A01, memory[33]=0xBEEF.
  - Required: edge 1 gives ifid_valid=0; edge 2 gives ifid_op=0x0A01, ifid_imm=0xBEEF, ifid_pc=32, ifid_two_word=1; then imem_addr=34.
- Stall hold:
  - Stimulus: stall=1 for 3 cycles while ifid_op=0x2002 is valid.
  - Required: all ifid_* outputs and imem_addr unchanged for those 3 cycles; fetch resumes at the next address.
- Redirect mid-instruction:
  - Stimulus: redirect=1, redirect_pc=0x100 while in state IMM.
  - Required: next ifid_valid=0, imem_addr=0x100; the following edge issues memory[0x100].
- Interrupt during a two-word instruction:
  - Stimulus: intr=1 in state IMM with op_pc=40.
  - Required: intr_ret_pc=40, imem_addr=0, intr_ack=1 for one cycle, ifid_valid=0.
- Wrap and priority:
  - Stimulus: with pc=0xFFFFF, a one-word fetch.
  - Required: pc=0.
  - Stimulus: intr, redirect and stall all 1 in the same cycle.
  - Required: the interrupt path is taken with intr_ret_pc=redirect_pc.
